pulse_width_generator: RTL

PULSE_WIDTH_GENERATOR -- requirements
Module: pulse_width_generator

---
 rtl/pulse_width_generator_pkg.sv | 14 +
 rtl/pulse_width_generator_timer.sv | 27 ++
 rtl/pulse_width_generator.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pulse_width_generator_pkg.sv
// Shared types and default sizes for the pulse width generator.
package pulse_pkg;

   localparam int DEFAULT_CNT_W = 16;
   localparam int DEFAULT_NUM_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2,
      FIN  = 2'd3
   } pulse_state_t;

endpackage

// File: rtl/pulse_width_generator_timer.sv
// Loadable down-counter that times both the high and the low phase of a pulse.
module pulse_timer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [CNT_W-1:0] value,
   output logic             expire
);

   logic [CNT_W-1:0] count;

   // A loaded value of N makes expire true on the N-th cycle after the load.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (count != '0) begin
         count <= count - CNT_W'(1);
      end
   end

   assign expire = (count == CNT_W'(1));

endmodule

// File: rtl/pulse_width_generator.sv
// Burst pulse generator: num pulses of width high cycles separated by gap low cycles.
// Define PULSE_GEN_ABORT_EN to add an abort input that ends a burst early.
module pulse_width_generator
   import pulse_pkg::*;
#(
   parameter int CNT_W = DEFAULT_CNT_W,
   parameter int NUM_W = DEFAULT_NUM_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [CNT_W-1:0] width,
   input  logic [CNT_W-1:0] gap,
   input  logic [NUM_W-1:0] num,
   output logic             pulse_out,
   output logic             busy,
   output logic             done,
   output logic [NUM_W-1:0] pulses_sent
`ifdef PULSE_GEN_ABORT_EN
   ,
   input  logic             abort
`endif
);

   pulse_state_t     state;
   logic [CNT_W-1:0] width_lat;
   logic [CNT_W-1:0] gap_lat;
   logic [NUM_W-1:0] num_lat;
   logic [CNT_W-1:0] gap_eff;
   logic [NUM_W:0]   sent_inc;
   logic             last_pulse;
   logic             start_ok;
   logic             timer_load;
   logic [CNT_W-1:0] timer_value;
   logic             timer_expire;

   assign start_ok   = start && (width != '0) && (num != '0);
   // A zero gap still needs one low cycle so consecutive pulses stay distinguishable.
   assign gap_eff    = (gap_lat == '0) ? CNT_W'(1) : gap_lat;
   assign sent_inc   = {1'b0, pulses_sent} + (NUM_W + 1)'(1);
   assign last_pulse = (sent_inc >= {1'b0, num_lat});

   always_comb begin
      timer_load  = 1'b0;
      timer_value = width_lat;
      case (state)
         IDLE: begin
            if (start_ok) begin
               timer_load  = 1'b1;
               timer_value = width;
            end
         end
         HIGH: begin
            if (timer_expire && !last_pulse) begin
               timer_load  = 1'b1;
               timer_value = gap_eff;
            end
         end
         LOW: begin
            if (timer_expire) begin
               timer_load  = 1'b1;
               timer_value = width_lat;
            end
         end
         default: begin
            timer_load = 1'b0;
         end
      endcase
   end

   pulse_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (timer_load),
      .value   (timer_value),
      .expire  (timer_expire)
   );

   // Outputs are set from the next state so every output is a plain flop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         width_lat   <= '0;
         gap_lat     <= '0;
         num_lat     <= '0;
         pulse_out   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         pulses_sent <= '0;
      end else begin
         case (state)
            IDLE: begin
               done      <= 1'b0;
               pulse_out <= 1'b0;
               busy      <= 1'b0;
               if (start_ok) begin
                  width_lat   <= width;
                  gap_lat     <= gap;
                  num_lat     <= num;
                  pulses_sent <= '0;
                  pulse_out   <= 1'b1;
                  busy        <= 1'b1;
                  state       <= HIGH;
               end
            end
            HIGH: begin
`ifdef PULSE_GEN_ABORT_EN
               if (abort) begin
                  pulse_out <= 1'b0;
                  done      <= 1'b1;
                  state     <= FIN;
               end else
`endif
               if (timer_expire) begin
                  if (pulses_sent != '1) begin
                     pulses_sent <= pulses_sent + NUM_W'(1);
                  end
                  pulse_out <= 1'b0;
                  if (last_pulse) begin
                     done  <= 1'b1;
                     state <= FIN;
                  end else begin
                     state <= LOW;
                  end
               end
            end
            LOW: begin
`ifdef PULSE_GEN_ABORT_EN
               if (abort) begin
                  done  <= 1'b1;
                  state <= FIN;
               end else
`endif
               if (timer_expire) begin
                  pulse_out <= 1'b1;
                  state     <= HIGH;
               end
            end
            FIN: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
